// File: rtl/flash_chip_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : flash_chip_responder_pkg
// Brief   : Opcodes, status bytes, FSM and output-mode encodings shared by
//           the NAND chip responder and its strobe synchroniser.
// Revision: 1.0  initial release
// ============================================================================
package flash_chip_responder_pkg;

  // Command opcodes seen on [7:0] during a CLE latch
  localparam logic [7:0] c_cmd_reset   = 8'hFF;
  localparam logic [7:0] c_cmd_read_id = 8'h90;
  localparam logic [7:0] c_cmd_status  = 8'h70;
  localparam logic [7:0] c_cmd_read    = 8'h00;
  localparam logic [7:0] c_cmd_confirm = 8'h30;

  // READ ID address bytes selecting the signature flavour
  localparam logic [7:0] c_id_addr_jedec = 8'h00;
  localparam logic [7:0] c_id_addr_onfi  = 8'h20;

  // Status byte returned by READ STATUS
  localparam logic [7:0] c_status_ready = 8'hE0;
  localparam logic [7:0] c_status_busy  = 8'h80;

  // "ONFI" signature, first byte in [7:0]
  localparam logic [31:0] c_onfi_sig = 32'h49_46_4E_4F;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_BUSY_RESET = 3'd1,
    ST_ID_ADDR    = 3'd2,
    ST_ID_OUT     = 3'd3,
    ST_RD_ADDR    = 3'd4,
    ST_RD_CONFIRM = 3'd5,
    ST_BUSY_READ  = 3'd6,
    ST_PAGE_OUT   = 3'd7
  } state_t;

  typedef enum logic [2:0] {
    MODE_NONE     = 3'd0,
    MODE_ID_JEDEC = 3'd1,
    MODE_ID_ONFI  = 3'd2,
    MODE_STATUS   = 3'd3,
    MODE_PAGE     = 3'd4
  } mode_t;

endpackage
`default_nettype wire

// File: rtl/flash_chip_responder_strobe_sync.sv
`default_nettype none
// ============================================================================
// Module  : flash_strobe_sync
// Brief   : Registers the NAND bus strobes into the master clock domain and
//           produces WE#-rise latch pulses and RE# fall/rise pulses.
// Revision: 1.0  initial release
// ============================================================================
module flash_strobe_sync (
  input  logic       i_master_clk,
  input  logic       i_reset,
  input  logic [7:0] i_chip_data,
  input  logic       i_chip_cs_n,
  input  logic       i_chip_cle,
  input  logic       i_chip_ale,
  input  logic       i_chip_we_n,
  input  logic       i_chip_re_n,
  output logic       o_cmd_latch,
  output logic       o_addr_latch,
  output logic       o_both_latch,
  output logic [7:0] o_latch_data,
  output logic       o_re_fall,
  output logic       o_re_rise,
  output logic       o_cs_active,
  output logic       o_re_low
);

  logic       r_cs_n, r_we_n, r_re_n, r_cle, r_ale;
  logic [7:0] r_data;
  logic       r_we_n_d, r_re_n_d, r_cle_d, r_ale_d;
  logic [7:0] r_data_d;
  logic       w_we_rise;

  // Two register stages: stage 1 gives the "now" strobe, stage 2 holds the
  // CLE/ALE/data that were present while WE# was still low.
  always_ff @(posedge i_master_clk) begin
    if (i_reset) begin
      r_cs_n   <= 1'b1;
      r_we_n   <= 1'b1;
      r_re_n   <= 1'b1;
      r_cle    <= 1'b0;
      r_ale    <= 1'b0;
      r_data   <= 8'h00;
      r_we_n_d <= 1'b1;
      r_re_n_d <= 1'b1;
      r_cle_d  <= 1'b0;
      r_ale_d  <= 1'b0;
      r_data_d <= 8'h00;
    end else begin
      r_cs_n   <= i_chip_cs_n;
      r_we_n   <= i_chip_we_n;
      r_re_n   <= i_chip_re_n;
      r_cle    <= i_chip_cle;
      r_ale    <= i_chip_ale;
      r_data   <= i_chip_data;
      r_we_n_d <= r_we_n;
      r_re_n_d <= r_re_n;
      r_cle_d  <= r_cle;
      r_ale_d  <= r_ale;
      r_data_d <= r_data;
    end
  end

  assign w_we_rise    = ~r_we_n_d & r_we_n & ~r_cs_n;
  assign o_cmd_latch  = w_we_rise & r_cle_d & ~r_ale_d;
  assign o_addr_latch = w_we_rise & r_ale_d & ~r_cle_d;
  assign o_both_latch = w_we_rise & r_ale_d & r_cle_d;
  assign o_latch_data = r_data_d;
  assign o_re_fall    = r_re_n_d & ~r_re_n & ~r_cs_n;
  assign o_re_rise    = ~r_re_n_d & r_re_n & ~r_cs_n;
  assign o_cs_active  = ~r_cs_n;
  assign o_re_low     = ~r_re_n;

endmodule
`default_nettype wire

// File: rtl/flash_chip_responder.sv
`default_nettype none
// ============================================================================
// Module  : flash_chip_responder
// Brief   : Chip end of the x16 NAND bus: decodes RESET, READ ID, READ STATUS
//           and PAGE READ, serves page words from an external sync memory.
// Revision: 1.0  initial release
// ============================================================================
module flash_chip_responder #(
  parameter int          COL_BITS          = 11,
  parameter int          ROW_BITS          = 16,
  parameter int          RESET_BUSY_CYCLES = 1000,
  parameter int          READ_BUSY_CYCLES  = 50,
  parameter logic [39:0] ID_BYTES          = 40'h00_95_B1_58_2C
) (
  input  logic                         i_master_clk,
  input  logic                         i_reset,
  input  logic [15:0]                  i_chip_data,
  input  logic                         i_chip_cs_n,
  input  logic                         i_chip_cle,
  input  logic                         i_chip_ale,
  input  logic                         i_chip_we_n,
  input  logic                         i_chip_re_n,
  output logic [15:0]                  o_chip_data,
  output logic                         o_chip_data_oe,
  output logic                         o_chip_ready,
  output logic [ROW_BITS+COL_BITS-1:0] o_mem_addr,
  output logic                         o_mem_rd,
  input  logic [15:0]                  i_mem_data,
  output logic                         o_proto_error
);
  import flash_chip_responder_pkg::*;

  localparam int MAX_BUSY = (RESET_BUSY_CYCLES > READ_BUSY_CYCLES) ? RESET_BUSY_CYCLES : READ_BUSY_CYCLES;
  localparam int CNT_W    = $clog2(MAX_BUSY + 1);

  logic             w_cmd_latch, w_addr_latch, w_both_latch, w_re_fall, w_re_rise, w_cs_active, w_re_low;
  logic [7:0]       w_latch_data;
  state_t           r_state, w_state_nxt;
  mode_t            r_mode, w_mode_nxt, r_prev_mode, w_prev_nxt;
  logic [CNT_W-1:0] r_busy_cnt, w_busy_val;
  logic             w_busy_load, w_busy, w_err, w_fetch, w_id_clr, w_addr_wr, w_page_adv;
  logic [2:0]       r_addr_cnt, w_addr_cnt_nxt, r_id_idx;
  logic [15:0]      r_col;
  logic [23:0]      r_row;
  logic [15:0]      r_prefetch, w_word;
  logic [7:0]       w_id_byte, w_onfi_byte;
  logic [COL_BITS-1:0] w_col_inc;
  logic             r_mem_rd_d;
  logic             w_unused_addr;

  flash_strobe_sync u_strobe_sync (
    .i_master_clk (i_master_clk),
    .i_reset      (i_reset),
    .i_chip_data  (i_chip_data[7:0]),
    .i_chip_cs_n  (i_chip_cs_n),
    .i_chip_cle   (i_chip_cle),
    .i_chip_ale   (i_chip_ale),
    .i_chip_we_n  (i_chip_we_n),
    .i_chip_re_n  (i_chip_re_n),
    .o_cmd_latch  (w_cmd_latch),
    .o_addr_latch (w_addr_latch),
    .o_both_latch (w_both_latch),
    .o_latch_data (w_latch_data),
    .o_re_fall    (w_re_fall),
    .o_re_rise    (w_re_rise),
    .o_cs_active  (w_cs_active),
    .o_re_low     (w_re_low)
  );

  // Only the low address bits address the memory; the upper bus byte is unused
  assign w_unused_addr = ^{r_row[23:ROW_BITS], r_col[15:COL_BITS], i_chip_data[15:8]};

  assign w_busy       = (r_state == ST_BUSY_RESET) || (r_state == ST_BUSY_READ);
  assign o_chip_ready = ~w_busy;
  assign w_col_inc    = r_col[COL_BITS-1:0] + COL_BITS'(1);
  assign w_page_adv   = w_re_rise && (r_mode == MODE_PAGE) && !w_busy;

  // Next state: busy expiry first, then the bus event of this clock
  always_comb begin
    w_state_nxt    = r_state;
    w_mode_nxt     = r_mode;
    w_prev_nxt     = r_prev_mode;
    w_err          = 1'b0;
    w_busy_load    = 1'b0;
    w_busy_val     = '0;
    w_addr_cnt_nxt = r_addr_cnt;
    w_addr_wr      = 1'b0;
    w_fetch        = 1'b0;
    w_id_clr       = 1'b0;
    if (w_busy && r_busy_cnt == '0) begin
      if (r_state == ST_BUSY_RESET) begin
        w_state_nxt = ST_IDLE;
      end else begin
        w_state_nxt = ST_PAGE_OUT;
        w_fetch     = 1'b1;
        if (r_mode == MODE_STATUS) w_prev_nxt = MODE_PAGE;
        else                       w_mode_nxt = MODE_PAGE;
      end
    end
    if (w_both_latch) begin
      w_err = 1'b1;
    end else if (w_cmd_latch) begin
      if (r_state == ST_RD_ADDR) w_err = 1'b1;
      if (w_latch_data == c_cmd_reset) begin
        w_state_nxt = ST_BUSY_RESET;
        w_mode_nxt  = MODE_NONE;
        w_prev_nxt  = MODE_NONE;
        w_busy_load = 1'b1;
        w_busy_val  = CNT_W'(RESET_BUSY_CYCLES - 1);
        w_fetch     = 1'b0;
      end else if (w_latch_data == c_cmd_status) begin
        if (w_mode_nxt != MODE_STATUS) w_prev_nxt = w_mode_nxt;
        w_mode_nxt = MODE_STATUS;
      end else if (w_busy) begin
        w_err = 1'b1;
      end else begin
        case (w_latch_data)
          c_cmd_read_id: begin
            w_state_nxt = ST_ID_ADDR;
            w_mode_nxt  = MODE_NONE;
          end
          c_cmd_read: begin
            if ((r_state == ST_ID_OUT || r_state == ST_PAGE_OUT) && r_mode == MODE_STATUS) begin
              w_mode_nxt = r_prev_mode;
            end else begin
              w_state_nxt    = ST_RD_ADDR;
              w_mode_nxt     = MODE_NONE;
              w_addr_cnt_nxt = 3'd0;
            end
          end
          c_cmd_confirm: begin
            if (r_state == ST_RD_CONFIRM) begin
              w_state_nxt = ST_BUSY_READ;
              w_busy_load = 1'b1;
              w_busy_val  = CNT_W'(READ_BUSY_CYCLES - 1);
            end else begin
              w_err = 1'b1;
            end
          end
          default: w_err = 1'b1;
        endcase
      end
    end else if (w_addr_latch) begin
      if (r_state == ST_ID_ADDR) begin
        if (w_latch_data == c_id_addr_jedec) begin
          w_state_nxt = ST_ID_OUT;
          w_mode_nxt  = MODE_ID_JEDEC;
          w_id_clr    = 1'b1;
        end else if (w_latch_data == c_id_addr_onfi) begin
          w_state_nxt = ST_ID_OUT;
          w_mode_nxt  = MODE_ID_ONFI;
          w_id_clr    = 1'b1;
        end else begin
          w_state_nxt = ST_IDLE;
          w_err       = 1'b1;
        end
      end else if (r_state == ST_RD_ADDR) begin
        w_addr_wr = 1'b1;
        if (r_addr_cnt == 3'd4) w_state_nxt = ST_RD_CONFIRM;
        else                    w_addr_cnt_nxt = r_addr_cnt + 3'd1;
      end
    end
    if (w_re_fall && (r_mode == MODE_NONE || (w_busy && r_mode != MODE_STATUS))) w_err = 1'b1;
  end

  // Identification byte selection
  always_comb begin
    w_id_byte   = ID_BYTES[39:32];
    w_onfi_byte = c_onfi_sig[31:24];
    case (r_id_idx)
      3'd0:    w_id_byte = ID_BYTES[7:0];
      3'd1:    w_id_byte = ID_BYTES[15:8];
      3'd2:    w_id_byte = ID_BYTES[23:16];
      3'd3:    w_id_byte = ID_BYTES[31:24];
      default: w_id_byte = ID_BYTES[39:32];
    endcase
    case (r_id_idx)
      3'd0:    w_onfi_byte = c_onfi_sig[7:0];
      3'd1:    w_onfi_byte = c_onfi_sig[15:8];
      3'd2:    w_onfi_byte = c_onfi_sig[23:16];
      default: w_onfi_byte = c_onfi_sig[31:24];
    endcase
  end

  // Word presented on the next RE# fall
  always_comb begin
    w_word = 16'h0000;
    case (r_mode)
      MODE_STATUS:   w_word = {8'h00, (w_busy ? c_status_busy : c_status_ready)};
      MODE_ID_JEDEC: w_word = {8'h00, w_id_byte};
      MODE_ID_ONFI:  w_word = {8'h00, w_onfi_byte};
      MODE_PAGE:     w_word = r_prefetch;
      default:       w_word = 16'h0000;
    endcase
    if (w_busy && r_mode != MODE_STATUS) w_word = 16'h0000;
  end

  // State, busy counter, address capture, memory fetch and bus outputs
  always_ff @(posedge i_master_clk) begin
    if (i_reset) begin
      r_state        <= ST_IDLE;
      r_mode         <= MODE_NONE;
      r_prev_mode    <= MODE_NONE;
      r_busy_cnt     <= '0;
      r_addr_cnt     <= 3'd0;
      r_id_idx       <= 3'd0;
      r_col          <= 16'h0000;
      r_row          <= 24'h000000;
      r_prefetch     <= 16'h0000;
      r_mem_rd_d     <= 1'b0;
      o_mem_rd       <= 1'b0;
      o_mem_addr     <= '0;
      o_chip_data    <= 16'h0000;
      o_chip_data_oe <= 1'b0;
      o_proto_error  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_mode        <= w_mode_nxt;
      r_prev_mode   <= w_prev_nxt;
      r_addr_cnt    <= w_addr_cnt_nxt;
      o_proto_error <= w_err;
      if (w_busy_load)          r_busy_cnt <= w_busy_val;
      else if (r_busy_cnt != '0) r_busy_cnt <= r_busy_cnt - CNT_W'(1);
      if (w_addr_wr) begin
        case (r_addr_cnt)
          3'd0:    r_col[7:0]   <= w_latch_data;
          3'd1:    r_col[15:8]  <= w_latch_data;
          3'd2:    r_row[7:0]   <= w_latch_data;
          3'd3:    r_row[15:8]  <= w_latch_data;
          default: r_row[23:16] <= w_latch_data;
        endcase
      end
      if (w_id_clr) begin
        r_id_idx <= 3'd0;
      end else if (w_re_rise && ((r_mode == MODE_ID_JEDEC && r_id_idx < 3'd4) ||
                                 (r_mode == MODE_ID_ONFI  && r_id_idx < 3'd3))) begin
        r_id_idx <= r_id_idx + 3'd1;
      end
      o_mem_rd <= 1'b0;
      if (w_fetch) begin
        o_mem_rd   <= 1'b1;
        o_mem_addr <= {r_row[ROW_BITS-1:0], r_col[COL_BITS-1:0]};
      end else if (w_page_adv) begin
        o_mem_rd             <= 1'b1;
        o_mem_addr           <= {r_row[ROW_BITS-1:0], w_col_inc};
        r_col[COL_BITS-1:0]  <= w_col_inc;
      end
      r_mem_rd_d <= o_mem_rd;
      if (r_mem_rd_d) r_prefetch <= i_mem_data;
      if (w_re_fall) o_chip_data <= w_word;
      o_chip_data_oe <= w_cs_active & w_re_low;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_flash_chip_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_flash_chip_responder
// Brief   : Directed bench; expected read words are queued as reads are
//           issued and a monitor compares them as the bus is driven.
// Revision: 1.0  initial release
// ============================================================================
module tb_flash_chip_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] chip_din;
  logic        cs_n, cle, ale, we_n, re_n;
  logic [15:0] chip_dout;
  logic        oe, ready, mem_rd, perr;
  logic [26:0] mem_addr;
  logic [15:0] mem_q = 16'h0000;

  int passed = 0, total = 0;
  int err_cnt = 0, mem_rd_cnt = 0, low_run = 0, last_low_run = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic        oe_prev = 1'b0;

  always #5 clk = ~clk;

  flash_chip_responder dut (
    .i_master_clk   (clk),
    .i_reset        (rst),
    .i_chip_data    (chip_din),
    .i_chip_cs_n    (cs_n),
    .i_chip_cle     (cle),
    .i_chip_ale     (ale),
    .i_chip_we_n    (we_n),
    .i_chip_re_n    (re_n),
    .o_chip_data    (chip_dout),
    .o_chip_data_oe (oe),
    .o_chip_ready   (ready),
    .o_mem_addr     (mem_addr),
    .o_mem_rd       (mem_rd),
    .i_mem_data     (mem_q),
    .o_proto_error  (perr)
  );

  function automatic logic [15:0] mem_word(input logic [26:0] a);
    logic [31:0] t;
    t = {5'd0, a} * 32'd7;
    return t[15:0] ^ 16'h5A3C;
  endfunction

  // Page memory model: data valid the clock after the read strobe
  always @(posedge clk) if (mem_rd) mem_q <= mem_word(mem_addr);

  // Monitor: counts events and checks each read word against the queue
  always @(negedge clk) begin
    if (perr) err_cnt++;
    if (mem_rd) mem_rd_cnt++;
    if (!ready) low_run++;
    else if (low_run != 0) begin last_low_run = low_run; low_run = 0; end
    if (oe && !oe_prev) begin
      total++;
      if (exp_q.size() == 0) begin
        $display("FAIL read_unexpected: got %h, no read expected", chip_dout);
      end else begin
        mon_exp = exp_q.pop_front();
        if (chip_dout === mon_exp) passed++;
        else $display("FAIL read_data: got %h expected %h", chip_dout, mon_exp);
      end
    end
    oe_prev = oe;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr_cycle(input logic c, input logic a, input logic [7:0] d);
    @(negedge clk);
    cle = c; ale = a; chip_din = {8'h00, d}; we_n = 1'b0;
    idle(2);
    we_n = 1'b1;
    @(negedge clk);
    cle = 1'b0; ale = 1'b0;
    @(negedge clk);
  endtask

  task automatic cmd(input logic [7:0] d);  wr_cycle(1'b1, 1'b0, d); endtask
  task automatic addr(input logic [7:0] d); wr_cycle(1'b0, 1'b1, d); endtask

  task automatic rd(input logic [15:0] e);
    exp_q.push_back(e);
    @(negedge clk);
    re_n = 1'b0;
    idle(3);
    re_n = 1'b1;
    idle(4);
  endtask

  task automatic page_setup(input logic [15:0] col, input logic [23:0] row);
    cmd(8'h00);
    addr(col[7:0]); addr(col[15:8]);
    addr(row[7:0]); addr(row[15:8]); addr(row[23:16]);
    cmd(8'h30);
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!ready && n < 3000) begin @(negedge clk); n++; end
    if (!ready) chk(name, 32'(ready), 32'd1);
    idle(2);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1; we_n = 1'b1; re_n = 1'b1; cle = 1'b0; ale = 1'b0;
    idle(2);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, m0;
    rst = 1'b1; chip_din = 16'h0000; cs_n = 1'b0; cle = 1'b0; ale = 1'b0;
    we_n = 1'b1; re_n = 1'b1;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", 32'(ready), 32'd1);
    chk("reset_oe", 32'(oe), 32'd0);
    chk("reset_mem_rd", 32'(mem_rd), 32'd0);
    chk("reset_err", 32'(perr), 32'd0);

    // Read with no data mode selected: zero word plus one error pulse
    e0 = err_cnt;
    rd(16'h0000);
    chk("err_read_none", 32'(err_cnt - e0), 32'd1);

    // RESET: busy length, status while busy and after
    last_low_run = 0;
    cmd(8'hFF);
    cmd(8'h70);
    rd(16'h0080);
    wait_ready("timeout_reset_busy");
    chk("reset_busy_len", 32'(last_low_run), 32'd1000);
    rd(16'h00E0);

    // READ ID, JEDEC and ONFI flavours
    cmd(8'h90); addr(8'h00);
    rd(16'h002C); rd(16'h0058); rd(16'h00B1); rd(16'h0095); rd(16'h0000);
    cmd(8'h90); addr(8'h20);
    rd(16'h004F); rd(16'h004E); rd(16'h0046); rd(16'h0049); rd(16'h0049);
    chk("oe_low_after_reads", 32'(oe), 32'd0);

    // PAGE READ at row 5, column 2
    last_low_run = 0;
    page_setup(16'h0002, 24'h000005);
    wait_ready("timeout_read_busy");
    chk("read_busy_len", 32'(last_low_run), 32'd50);
    rd(mem_word({16'd5, 11'd2}));
    rd(mem_word({16'd5, 11'd3}));
    rd(mem_word({16'd5, 11'd4}));
    chk("mem_addr_after_3", 32'(mem_addr), 32'({16'd5, 11'd5}));

    // Status in the middle of a page stream, then resume without address
    cmd(8'h70);
    rd(16'h00E0);
    cmd(8'h00);
    rd(mem_word({16'd5, 11'd5}));

    // Column wrap at the end of the page
    page_setup(16'h07FF, 24'h000005);
    wait_ready("timeout_wrap_busy");
    rd(mem_word({16'd5, 11'h7FF}));
    rd(mem_word({16'd5, 11'd0}));

    // CLE and ALE together: one error, stream unaffected
    e0 = err_cnt;
    wr_cycle(1'b1, 1'b1, 8'h00);
    idle(2);
    chk("err_cle_ale", 32'(err_cnt - e0), 32'd1);
    chk("ready_after_cle_ale", 32'(ready), 32'd1);
    rd(mem_word({16'd5, 11'd1}));

    // Unknown opcode: one error, stream unaffected
    e0 = err_cnt;
    cmd(8'h45);
    idle(2);
    chk("err_bad_cmd", 32'(err_cnt - e0), 32'd1);
    rd(mem_word({16'd5, 11'd2}));

    // READ ID while busy: one error, busy and page read unaffected
    last_low_run = 0;
    page_setup(16'h0010, 24'h000001);
    e0 = err_cnt;
    cmd(8'h90);
    idle(2);
    chk("err_cmd_busy", 32'(err_cnt - e0), 32'd1);
    wait_ready("timeout_busy_err");
    chk("busy_len_unchanged", 32'(last_low_run), 32'd50);
    rd(mem_word({16'd1, 11'h010}));

    // Reset during BUSY_READ: ready immediately, no fetch afterwards
    page_setup(16'h0003, 24'h000002);
    idle(10);
    chk("busy_before_reset", 32'(ready), 32'd0);
    pulse_reset();
    chk("ready_after_reset", 32'(ready), 32'd1);
    chk("oe_after_reset", 32'(oe), 32'd0);
    m0 = mem_rd_cnt;
    idle(60);
    chk("no_fetch_after_reset", 32'(mem_rd_cnt - m0), 32'd0);
    cmd(8'h90); addr(8'h00);
    rd(16'h002C);

    // Reset during address entry, then a clean page read
    cmd(8'h00); addr(8'h20); addr(8'h00);
    pulse_reset();
    chk("ready_after_addr_reset", 32'(ready), 32'd1);
    page_setup(16'h0020, 24'h000003);
    wait_ready("timeout_after_addr_reset");
    rd(mem_word({16'd3, 11'h020}));
    rd(mem_word({16'd3, 11'h021}));

    idle(4);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
